// File: rtl/rom_stream_reader.sv
// ROM address sequencer + 4-entry stream FIFO with credit-gated issue.
// Optional final-beat marker m_last_o when ROM_STREAM_LAST_EN is defined.
`timescale 1ns/1ps

// Generic synchronous FIFO, power-of-two depth.
// Latency: a write is visible at the head the cycle after the push edge.
// Backpressure: pops only on rd_rdy; writes while full are dropped, so the caller must hold credit.
module sfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_wr, do_rd;

  assign rd_vld = (cnt_q != '0);
  assign rd_dat = mem_q[rd_ptr_q];
  assign cnt    = cnt_q;
  assign do_rd  = rd_vld && rd_rdy;
  assign do_wr  = wr_vld && (cnt_q != CW'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_dat;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// Walks [base, base+len) through a 1-cycle ROM and streams the words out.
// Latency: first beat valid 2 cycles after the start-sample edge, then one beat per cycle.
// Backpressure: issue stalls when FIFO occupancy + in-flight reads reaches 4; no ready->issue path.
module rom_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
`ifdef ROM_STREAM_LAST_EN
  ,
  output logic                  m_last_o
`endif
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         len_q, issue_cnt_q, len_clamped;
  logic                  issue_vld_q, rom_vld_q, done_q;
  logic                  issue, start_ok, done_d, drained, pop;
  logic [2:0]            fifo_cnt, credit_used;
  logic                  fifo_vld;
  logic [DATA_WIDTH-1:0] fifo_dat;

  sfifo #(.W(DATA_WIDTH), .DEPTH(4)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wr_vld (rom_vld_q),
    .wr_dat (rom_data_i),
    .rd_rdy (m_ready_i),
    .rd_vld (fifo_vld),
    .rd_dat (fifo_dat),
    .cnt    (fifo_cnt)
  );

  assign pop         = fifo_vld && m_ready_i;
  assign len_clamped = (length_i > MAX_LEN) ? MAX_LEN : length_i;
  // Registered occupancy only: a same-cycle pop does not free a credit.
  assign credit_used = fifo_cnt + {2'b00, issue_vld_q} + {2'b00, rom_vld_q};
  assign drained     = !issue_vld_q && !rom_vld_q &&
                       ((fifo_cnt == 3'd0) || ((fifo_cnt == 3'd1) && pop));

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    start_ok = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            issue   = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue_cnt_q == len_q) state_d = DRAIN;
        else if (credit_used < 3'd4) issue = 1'b1;
      end
      DRAIN: begin
        if (drained) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      issue_vld_q <= 1'b0;
      rom_vld_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      issue_vld_q <= issue;
      rom_vld_q   <= issue_vld_q;
      if (start_ok) len_q <= len_clamped;
      if (issue) begin
        addr_q      <= (state_q == IDLE) ? base_addr_i : addr_q + ADDR_WIDTH'(1);
        issue_cnt_q <= (state_q == IDLE) ? LW'(1) : issue_cnt_q + LW'(1);
      end
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign rom_addr_o = addr_q;
  assign m_valid_o  = fifo_vld;
  assign m_data_o   = fifo_vld ? fifo_dat : '0;

`ifdef ROM_STREAM_LAST_EN
  logic [LW-1:0] beat_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)       beat_cnt_q <= '0;
    else if (start_ok) beat_cnt_q <= '0;
    else if (pop)      beat_cnt_q <= beat_cnt_q + LW'(1);
  end

  assign m_last_o = fifo_vld && (beat_cnt_q == len_q - LW'(1));
`endif
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a 1-cycle registered ROM model (mem[i] = i & 0xFF).
`timescale 1ns/1ps

module tb_rom_stream_reader;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [9:0]  base_addr_i;
  logic [10:0] length_i;
  logic        busy_o, done_o;
  logic [9:0]  rom_addr_o;
  logic [7:0]  rom_data_i = 8'd0;
  logic [7:0]  m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic        m_last_o;

  int checks   = 0;
  int failures = 0;
  logic [7:0] got[$];
  bit         lastq[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) rom_data_i <= rom_addr_o[7:0];

  rom_stream_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .length_i    (length_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i)
`ifdef ROM_STREAM_LAST_EN
    ,
    .m_last_o    (m_last_o)
`endif
  );

`ifndef ROM_STREAM_LAST_EN
  assign m_last_o = 1'b0;
`endif

  // Record the handshake that the coming edge will complete, then advance one cycle.
  task automatic cyc();
    if (m_valid_o && m_ready_i) begin
      got.push_back(m_data_o);
      lastq.push_back(m_last_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_until_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      cyc();
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic kick(input logic [9:0] base, input logic [10:0] len);
    start_i = 1'b1; base_addr_i = base; length_i = len;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; length_i = '0; m_ready_i = 1'b0;
    repeat (3) cyc();
    checks++; if (busy_o !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (rom_addr_o !== 10'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rom_addr_o); end
    checks++; if (m_valid_o !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid_o); end
    checks++; if (m_data_o !== 8'd0)    begin failures++; $display("FAIL reset_data got=%0d exp=0", m_data_o); end
    checks++; if (m_last_o !== 1'b0)    begin failures++; $display("FAIL reset_last got=%b exp=0", m_last_o); end
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    got.delete(); lastq.delete();
    m_ready_i = 1'b1;
    kick(10'd16, 11'd4);
    checks++; if (busy_o !== 1'b1)       begin failures++; $display("FAIL basic_busy got=%b exp=1", busy_o); end
    checks++; if (rom_addr_o !== 10'd16) begin failures++; $display("FAIL basic_addr0 got=%0d exp=16", rom_addr_o); end
    checks++; if (m_valid_o !== 1'b0)    begin failures++; $display("FAIL basic_early_valid_e0 got=%b exp=0", m_valid_o); end
    cyc();
    checks++; if (m_valid_o !== 1'b0)    begin failures++; $display("FAIL basic_early_valid_e1 got=%b exp=0", m_valid_o); end
    checks++; if (rom_addr_o !== 10'd17) begin failures++; $display("FAIL basic_addr1 got=%0d exp=17", rom_addr_o); end
    cyc();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== 8'(16 + k)) begin
        failures++; $display("FAIL basic_beat%0d valid=%b data=%0d exp valid=1 data=%0d", k, m_valid_o, m_data_o, 16 + k);
      end
`ifdef ROM_STREAM_LAST_EN
      checks++;
      if (m_last_o !== (k == 3)) begin
        failures++; $display("FAIL basic_last%0d got=%b exp=%b", k, m_last_o, (k == 3));
      end
`endif
      cyc();
    end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
      failures++; $display("FAIL basic_done done=%b busy=%b valid=%b exp 1/0/0", done_o, busy_o, m_valid_o);
    end
    cyc();
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d [4];
    bit ok;
    exp_d[0] = 8'd254; exp_d[1] = 8'd255; exp_d[2] = 8'd0; exp_d[3] = 8'd1;
    got.delete(); lastq.delete();
    m_ready_i = 1'b1;
    kick(10'd1022, 11'd4);
    cyc(); cyc();
    checks++; if (rom_addr_o !== 10'd0) begin failures++; $display("FAIL wrap_addr got=%0d exp=0", rom_addr_o); end
    run_until_done(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=no_done exp=done"); end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_d[k]) begin failures++; $display("FAIL wrap_beat%0d got=%0d exp=%0d", k, got[k], exp_d[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pat;
    logic [7:0]  held;
    bit          stalled, ok;
    pat = 32'b1001_0110_1100_1001_0011_0101_1001_0110;
    got.delete(); lastq.delete();
    m_ready_i = 1'b0;
    kick(10'd100, 11'd10);
    repeat (10) cyc();
    checks++; if (rom_addr_o !== 10'd103) begin failures++; $display("FAIL bp_stall_addr got=%0d exp=103", rom_addr_o); end
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'd100) begin
      failures++; $display("FAIL bp_stall_head valid=%b data=%0d exp valid=1 data=100", m_valid_o, m_data_o);
    end
    stalled = 1'b1; held = 8'd100; ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (stalled) begin
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== held) begin
          failures++; $display("FAIL bp_hold cyc%0d valid=%b data=%0d exp valid=1 data=%0d", i, m_valid_o, m_data_o, held);
        end
      end
      m_ready_i = pat[i % 32];
      stalled = m_valid_o && !m_ready_i;
      held = m_data_o;
      cyc();
      if (done_o === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (got.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", got.size()); end
    for (int k = 0; k < 10 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== 8'(100 + k)) begin failures++; $display("FAIL bp_beat%0d got=%0d exp=%0d", k, got[k], 100 + k); end
`ifdef ROM_STREAM_LAST_EN
      checks++;
      if (lastq[k] !== (k == 9)) begin failures++; $display("FAIL bp_last%0d got=%b exp=%b", k, lastq[k], (k == 9)); end
`endif
    end
    m_ready_i = 1'b1;
  endtask

  task automatic test_zero_and_clamp();
    bit ok, bad;
    int nlast;
    got.delete(); lastq.delete();
    m_ready_i = 1'b1;
    kick(10'd7, 11'd0);
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("FAIL zero_done done=%b busy=%b exp 1/0", done_o, busy_o);
    end
    cyc();
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
      failures++; $display("FAIL zero_after done=%b busy=%b valid=%b exp 0/0/0", done_o, busy_o, m_valid_o);
    end
    cyc();
    checks++; if (got.size() != 0) begin failures++; $display("FAIL zero_beats got=%0d exp=0", got.size()); end

    kick(10'd0, 11'd2000);
    run_until_done(1200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL clamp_timeout got=no_done exp=done"); end
    checks++; if (got.size() != 1024) begin failures++; $display("FAIL clamp_count got=%0d exp=1024", got.size()); end
    bad = 1'b0; nlast = 0;
    for (int k = 0; k < got.size(); k++) begin
      if (got[k] !== 8'(k)) bad = 1'b1;
      if (lastq[k]) nlast++;
    end
    checks++; if (bad) begin failures++; $display("FAIL clamp_data got=out_of_order exp=in_order"); end
`ifdef ROM_STREAM_LAST_EN
    checks++; if (nlast != 1 || lastq[got.size()-1] !== 1'b1) begin
      failures++; $display("FAIL clamp_last got=%0d_markers exp=1_on_final", nlast);
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'd8; exp_d[1] = 8'd9; exp_d[2] = 8'd40; exp_d[3] = 8'd41;
    got.delete(); lastq.delete();
    m_ready_i = 1'b1;
    kick(10'd8, 11'd2);
    run_until_done(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_first_timeout got=no_done exp=done"); end
    kick(10'd40, 11'd2);
    checks++; if (busy_o !== 1'b1 || rom_addr_o !== 10'd40) begin
      failures++; $display("FAIL b2b_restart busy=%b addr=%0d exp 1/40", busy_o, rom_addr_o);
    end
    run_until_done(30, ok);
    checks++; if (!ok || got.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_d[k]) begin failures++; $display("FAIL b2b_beat%0d got=%0d exp=%0d", k, got[k], exp_d[k]); end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    got.delete(); lastq.delete();
    m_ready_i = 1'b1;
    kick(10'd200, 11'd6);
    cyc(); cyc();
    kick(10'd0, 11'd3);
    run_until_done(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ign_timeout got=no_done exp=done"); end
    checks++; if (got.size() != 6) begin failures++; $display("FAIL ign_count got=%0d exp=6", got.size()); end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== 8'(200 + k)) begin failures++; $display("FAIL ign_beat%0d got=%0d exp=%0d", k, got[k], 200 + k); end
    end
    cyc(); cyc();
    checks++; if (busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
      failures++; $display("FAIL ign_restart busy=%b valid=%b exp 0/0", busy_o, m_valid_o);
    end
  endtask

  task automatic test_mid_reset();
    bit ok, leak;
    m_ready_i = 1'b1;
    kick(10'd50, 11'd8);
    repeat (3) cyc();
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || rom_addr_o !== 10'd0) begin
      failures++; $display("FAIL rst_ctrl busy=%b done=%b addr=%0d exp 0/0/0", busy_o, done_o, rom_addr_o);
    end
    checks++; if (m_valid_o !== 1'b0 || m_data_o !== 8'd0 || m_last_o !== 1'b0) begin
      failures++; $display("FAIL rst_stream valid=%b data=%0d last=%b exp 0/0/0", m_valid_o, m_data_o, m_last_o);
    end
    leak = 1'b0;
    repeat (3) begin
      cyc();
      if (m_valid_o !== 1'b0 || busy_o !== 1'b0) leak = 1'b1;
    end
    checks++; if (leak) begin failures++; $display("FAIL rst_inflight got=stale_activity exp=idle"); end
    got.delete(); lastq.delete();
    kick(10'd300, 11'd3);
    run_until_done(30, ok);
    checks++; if (!ok || got.size() != 3) begin failures++; $display("FAIL rst_fresh_count got=%0d exp=3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== 8'(44 + k)) begin failures++; $display("FAIL rst_fresh_beat%0d got=%0d exp=%0d", k, got[k], 44 + k); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_clamp();
    test_back_to_back();
    test_start_ignored();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
